// File: rtl/dmem_readback_pkg.sv
// dmem_readback_pkg
//   Shared constants and types for the DataMemory readback engine.
//   - RB_MEM_LATENCY : DataMemory read latency in cycles (fixed at 1)
//   - RB_FIFO_DEPTH  : depth of the return-data FIFO (2)
//   - rb_state_e     : readback FSM encodings RB_IDLE/RB_ISSUE/RB_DRAIN/RB_FIN
//   - RB_ADDR_W / RB_DATA_W : default widths, taken from DATAMEM_ADDR_WIDTH /
//     DATA_WORD_LENGTH.
`ifndef DATAMEM_ADDR_WIDTH
`define DATAMEM_ADDR_WIDTH 8
`endif

`ifndef DATA_WORD_LENGTH
`define DATA_WORD_LENGTH 32
`endif

package dmem_readback_pkg;

    localparam int RB_ADDR_W = `DATAMEM_ADDR_WIDTH;
    localparam int RB_DATA_W = `DATA_WORD_LENGTH;

    localparam int RB_MEM_LATENCY = 1;
    localparam int RB_FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        RB_IDLE  = 2'd0,
        RB_ISSUE = 2'd1,
        RB_DRAIN = 2'd2,
        RB_FIN   = 2'd3
    } rb_state_e;

endpackage

// File: rtl/dmem_readback_fifo2.sv
// readback_fifo2
//   Two-entry fall-through FIFO. When empty, a pushed word is presented on
//   rd_data in the same cycle, so a beat can be consumed the cycle its data
//   returns from memory. A simultaneous push and pop leaves count unchanged.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset (flushes FIFO)
//     push, wr_data     write strobe and word
//     pop               consume the head word (ignored when nothing valid)
//     rd_data, rd_valid head word (zero when not valid) and its valid flag
//     count, full, empty occupancy of stored entries
module readback_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic         w_push;
    logic         w_pop;
    logic [W-1:0] w_head;

    assign empty    = (r_count == 2'd0);
    assign full     = (r_count == 2'd2);
    assign count    = r_count;
    assign rd_valid = !empty || push;

    // Fall-through: with nothing stored the incoming word is the head.
    assign w_head  = empty ? wr_data : r_mem[r_rd_ptr];
    assign rd_data = rd_valid ? w_head : '0;

    assign w_pop  = pop && rd_valid;
    assign w_push = push && (!full || w_pop);

    // Pass-through (empty, push and pop together) still writes the slot and
    // advances both pointers; they stay aligned and count does not move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_readback.sv
// dmem_readback
//   Host-side reader for DataMemory. A start pulse walks word_count words from
//   base_addr (wrapping modulo 2^ADDR_W) and streams them out on a valid/ready
//   interface tagged with source address and last-beat flag.
//   Optional feature macro: READBACK_CHECKSUM_EN -- when defined, checksum is
//   the running modulo-2^DATA_W sum of handshaked beats of the current sweep;
//   otherwise checksum is tied to zero.
//   Ports:
//     clk, reset              clock, asynchronous active-low reset
//     start, base_addr, word_count   sweep request (sampled only in IDLE)
//     busy, done              sweep in progress / one-cycle completion pulse
//     DataAddress, mem_rd     DataMemory read request
//     DataToRead              DataMemory read data (1 cycle after mem_rd)
//     out_valid, out_ready, out_data, out_addr, out_last   output stream
//     checksum                sum of streamed words (see macro above)
module dmem_readback
    import dmem_readback_pkg::*;
#(
    parameter int ADDR_W = RB_ADDR_W,
    parameter int DATA_W = RB_DATA_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] DataAddress,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] DataToRead,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum
);

    localparam int FW = 1 + ADDR_W + DATA_W;

    rb_state_e         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_addr;
    logic              r_inflight_last;
    logic              r_empty_sweep;
    logic              r_busy;
    logic              r_done;

    logic [1:0]        w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_fifo_valid;
    logic [FW-1:0]     w_fifo_head;
    logic              w_credit_ok;
    logic              w_mem_rd;
    logic              w_final_rd;
    logic              w_xfer;
    logic              w_last_xfer;

    // A read is only issued if the returning word is guaranteed a FIFO slot
    // even when the consumer never pops: outstanding read + stored < depth.
    // Memory latency of RB_MEM_LATENCY=1 bounds the outstanding reads to one.
    assign w_credit_ok = !w_fifo_full &&
                         (({1'b0, r_inflight} + w_fifo_count) < 2'(RB_FIFO_DEPTH));
    assign w_mem_rd    = (r_state == RB_ISSUE) && w_credit_ok;
    assign w_final_rd  = w_mem_rd && (r_remaining == CNT_W'(1));
    assign w_xfer      = w_fifo_valid && out_ready;
    assign w_last_xfer = w_xfer && out_last;

    assign mem_rd      = w_mem_rd;
    assign DataAddress = r_addr;
    assign busy        = r_busy;
    assign done        = r_done;

    readback_fifo2 #(.W(FW)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (r_inflight),
        .wr_data  ({r_inflight_last, r_inflight_addr, DataToRead}),
        .pop      (w_xfer),
        .rd_data  (w_fifo_head),
        .rd_valid (w_fifo_valid),
        .count    (w_fifo_count),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty)
    );

    assign out_valid = w_fifo_valid;
    assign {out_last, out_addr, out_data} = w_fifo_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= RB_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_inflight_last <= 1'b0;
            r_empty_sweep   <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_mem_rd;

            // Address/last tags ride alongside the outstanding read so they
            // enter the FIFO together with the returned word.
            if (w_mem_rd) begin
                r_inflight_addr <= r_addr;
                r_inflight_last <= w_final_rd;
                r_addr          <= r_addr + ADDR_W'(1);
                r_remaining     <= r_remaining - CNT_W'(1);
            end

            case (r_state)
                RB_IDLE: begin
                    if (start) begin
                        r_busy        <= 1'b1;
                        r_addr        <= base_addr;
                        r_remaining   <= word_count;
                        r_empty_sweep <= (word_count == '0);
                        // An empty sweep issues nothing; it waits one cycle in
                        // DRAIN (condition trivially met) so done lands two
                        // cycles after start.
                        r_state       <= (word_count == '0) ? RB_DRAIN : RB_ISSUE;
                    end
                end
                RB_ISSUE: begin
                    if (w_final_rd) r_state <= RB_DRAIN;
                end
                RB_DRAIN: begin
                    // The last-tagged beat is the final FIFO entry, so its
                    // handshake means the FIFO is drained and nothing is
                    // outstanding.
                    if (w_last_xfer ||
                        (r_empty_sweep && w_fifo_empty && !r_inflight)) begin
                        r_state <= RB_FIN;
                        r_done  <= 1'b1;
                    end
                end
                RB_FIN: begin
                    r_busy        <= 1'b0;
                    r_empty_sweep <= 1'b0;
                    r_state       <= RB_IDLE;
                end
                default: r_state <= RB_IDLE;
            endcase
        end
    end

`ifdef READBACK_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if ((r_state == RB_IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum + out_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dmem_readback.sv
module tb_dmem_readback;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic          busy, done, mem_rd;
    logic [AW-1:0] DataAddress;
    logic [DW-1:0] DataToRead;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data, checksum;
    logic [AW-1:0] out_addr;

    dmem_readback #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done),
        .DataAddress(DataAddress), .mem_rd(mem_rd), .DataToRead(DataToRead),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // DataMemory model: registered read, one cycle latency.
    logic [DW-1:0] ram [32];
    logic [DW-1:0] rd_q = '0;
    always @(posedge clk) if (mem_rd) rd_q <= ram[DataAddress];
    assign DataToRead = rd_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected beats {last, addr, data}.
    logic [21:0] exp_q [$];
    logic [DW-1:0] exp_sum;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int          beat_total = 0;
    int          rd_total = 0;
    int          last_beat_cyc = 0;
    int          occ = 0;
    int          infl = 0;
    logic        prev_stall = 1'b0;
    logic [21:0] prev_beat = '0;

    always @(negedge clk) begin
        logic xfer;
        logic [21:0] e;
        if (!reset) begin
            exp_q.delete();
            occ = 0; infl = 0; prev_stall = 1'b0;
        end else begin
            if (mem_rd) begin
                rd_total++;
                chk("credit", 32'(infl + occ < 2), 32'd1);
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_beat", 32'({out_last, out_addr, out_data}), 32'(prev_beat));
            end
            xfer = out_valid && out_ready;
            if (xfer) begin
                beat_total++;
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat", 32'({out_last, out_addr, out_data}), 32'(e));
                end
                if (out_last) last_beat_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_addr, out_data};
            occ  = occ + infl - (xfer ? 1 : 0);
            infl = mem_rd ? 1 : 0;
        end
    end

    task automatic start_sweep(input logic [AW-1:0] b, input logic [CW-1:0] c);
        logic [AW-1:0] a;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; word_count = c;
        exp_sum = '0;
        for (int i = 0; i < int'(c); i++) begin
            a = b + AW'(i);
            exp_q.push_back({(i == int'(c) - 1), a, ram[a]});
            exp_sum = exp_sum + ram[a];
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input bit bp, input string tag);
        int dc;
        int k;
        logic [DW-1:0] ck;
        dc = -1; k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin dc = cyc; break; end
            @(posedge clk); #1;
            if (bp) out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(dc >= 0), 32'd1);
        if (dc >= 0) begin
            chk({tag, "_done_after_last"}, 32'(dc), 32'(last_beat_cyc + 1));
`ifdef READBACK_CHECKSUM_EN
            ck = exp_sum;
`else
            ck = '0;
`endif
            chk({tag, "_checksum"}, 32'(checksum), 32'(ck));
            chk({tag, "_busy_in_fin"}, 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
        chk({tag, "_no_leftover"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int snap_b, snap_r;
        for (int i = 0; i < 32; i++) ram[i] = DW'(16'h0100 + i);
        ram[0] = 16'd5; ram[1] = 16'd6; ram[2] = 16'd7; ram[3] = 16'd8;
        reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_addr", 32'(DataAddress), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'({out_last, out_addr, out_data}), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Basic sweep
        start_sweep(5'd0, 6'd4);
        @(negedge clk);
        chk("basic_rd_first", 32'(mem_rd), 32'd1);
        chk("basic_addr_first", 32'(DataAddress), 32'd0);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_no_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("basic_first_valid", 32'(out_valid), 32'd1);
        chk("basic_first_data", 32'(out_data), 32'd5);
        run_until_done(1'b0, "basic");

        // Backpressure
        start_sweep(5'd0, 6'd4);
        run_until_done(1'b1, "bp");

        // Wrap
        start_sweep(5'd31, 6'd3);
        run_until_done(1'b0, "wrap");

        // Zero count
        snap_b = beat_total; snap_r = rd_total;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 5'd7; word_count = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("zero_done_clear", 32'(done), 32'd0);
        chk("zero_busy_clear", 32'(busy), 32'd0);
        chk("zero_no_reads", 32'(rd_total - snap_r), 32'd0);
        chk("zero_no_beats", 32'(beat_total - snap_b), 32'd0);

        // Start ignored while busy
        start_sweep(5'd0, 6'd4);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 5'd10; word_count = 6'd2;
        @(posedge clk); #1;
        start = 1'b0;
        run_until_done(1'b0, "ignore");

        // Reset abort after two beats
        snap_b = beat_total;
        start_sweep(5'd0, 6'd8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (beat_total >= snap_b + 2) break;
        end
        chk("abort_two_beats", 32'(beat_total - snap_b), 32'd2);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mem_rd", 32'(mem_rd), 32'd0);
        chk("abort_addr", 32'(DataAddress), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_out", 32'({out_last, out_addr, out_data}), 32'd0);
        chk("abort_checksum", 32'(checksum), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_abort_done", 32'(done), 32'd0);
        chk("post_abort_valid", 32'(out_valid), 32'd0);
        chk("post_abort_rd", 32'(mem_rd), 32'd0);
        snap_b = beat_total;
        start_sweep(5'd3, 6'd1);
        run_until_done(1'b0, "single");
        chk("single_beats", 32'(beat_total - snap_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
